// File: rtl/checkbits_seq_monitor.sv
// Sequences a firmware self-test by watching the checkbits status bus for start/pass codes.
// Optional code history FIFO is built when CHECKBITS_MON_LOG_EN is defined.
//
// state      | meaning
// IDLE       | waiting for the first arm pulse, codes are not accepted
// WAIT_START | armed, waiting for START_CODE
// RUN        | test running, timeout counter active
// PASS       | PASS_CODE seen before the timeout, held until reset or arm
// TIMEOUT    | cycle budget exhausted, held until reset or arm
module checkbits_seq_monitor #(
  parameter logic [15:0] START_CODE     = 16'hAB40,
  parameter logic [15:0] PASS_CODE      = 16'hAB51,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] checkbits,
  input  logic        arm,
  output logic        started,
  output logic        passed,
  output logic        timed_out,
  output logic [15:0] last_code,
  output logic [7:0]  code_count,
  input  logic        log_pop,
  output logic        log_valid,
  output logic [15:0] log_data
);

  localparam logic [3:0] STABLE_N  = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, RUN, PASS, TIMEOUT} state_t;

  state_t      state;
  logic [15:0] sync_meta;
  logic [15:0] sync_q;
  logic [15:0] stab_val;
  logic [3:0]  stab_cnt;
  logic [23:0] tmo_cnt;
  logic        changed;
  logic        reach;
  logic        accept;
  logic        tmo_hit;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= checkbits;
      sync_q    <= sync_meta;
    end
  end

  // Counter holds at STABLE_N so a steady code is accepted only once per run.
  assign changed = (sync_q != stab_val);
  assign reach   = changed ? (STABLE_N == 4'd1) : (stab_cnt == STABLE_M1);
  assign accept  = reach && (sync_q != last_code) && (state != IDLE) && !arm;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stab_val <= '0;
      stab_cnt <= '0;
    end else if (changed) begin
      stab_val <= sync_q;
      stab_cnt <= 4'd1;
    end else if (stab_cnt != STABLE_N) begin
      stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // Terminal count is judged on the value being written, so the flag lands
  // exactly TIMEOUT_CYCLES edges after RUN entry.
  assign tmo_hit = (state == RUN) && ((tmo_cnt + 24'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      started    <= 1'b0;
      passed     <= 1'b0;
      timed_out  <= 1'b0;
      last_code  <= '0;
      code_count <= '0;
      tmo_cnt    <= '0;
    end else if (arm) begin
      state      <= WAIT_START;
      started    <= 1'b0;
      passed     <= 1'b0;
      timed_out  <= 1'b0;
      code_count <= '0;
      tmo_cnt    <= '0;
    end else begin
      if (accept) begin
        last_code <= sync_q;
        if (code_count != 8'hFF) code_count <= code_count + 8'd1;
      end
      unique case (state)
        WAIT_START: begin
          if (accept && (sync_q == START_CODE)) begin
            state   <= RUN;
            started <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        RUN: begin
          tmo_cnt <= tmo_cnt + 24'd1;
          if (accept && (sync_q == PASS_CODE)) begin
            state  <= PASS;
            passed <= 1'b1;
          end else if (tmo_hit) begin
            state     <= TIMEOUT;
            timed_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHECKBITS_MON_LOG_EN
  logic [15:0] fifo_mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  fifo_cnt;
  logic        do_pop;
  logic        do_push;

  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign do_pop  = log_pop && (fifo_cnt != 3'd0);
  assign do_push = accept && ((fifo_cnt != 3'd4) || do_pop);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else if (arm) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= sync_q;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  assign log_valid = (fifo_cnt != 3'd0);
  assign log_data  = log_valid ? fifo_mem[rd_ptr] : 16'h0000;
`else
  logic unused_log_pop;
  assign unused_log_pop = log_pop;
  assign log_valid      = 1'b0;
  assign log_data       = 16'h0000;
`endif

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Self-checking bench for checkbits_seq_monitor: vector table, corner-case sequences
// and a randomized run against a run-length based reference model.
module tb_checkbits_seq_monitor;

  localparam logic [15:0] START = 16'hAB40;
  localparam logic [15:0] PASSC = 16'hAB51;
  localparam int S = 4;
  localparam int T = 100;
  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_RUN = 2, ST_PASS = 3, ST_TMO = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] checkbits = 16'h0;
  logic        arm = 1'b0;
  logic        log_pop = 1'b0;
  logic        started, passed, timed_out, log_valid;
  logic [15:0] last_code, log_data;
  logic [7:0]  code_count;

  int checks = 0;
  int failures = 0;

  checkbits_seq_monitor #(.TIMEOUT_CYCLES(24'd100)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .checkbits(checkbits), .arm(arm),
    .started(started), .passed(passed), .timed_out(timed_out),
    .last_code(last_code), .code_count(code_count),
    .log_pop(log_pop), .log_valid(log_valid), .log_data(log_data)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // reference model state
  logic [15:0] hist[$];
  logic [15:0] m_fifo[$];
  int          m_state, m_entry, m_count;
  logic [15:0] m_last;
  logic        m_started, m_passed, m_timed;

  typedef struct {
    logic        do_arm;
    logic [15:0] code;
    int          cycles;
    logic        e_started;
    logic        e_passed;
    logic        e_timed_out;
    logic [7:0]  e_count;
    logic [15:0] e_last;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_fifo.delete();
    m_state = ST_IDLE; m_entry = 0; m_count = 0; m_last = 16'h0;
    m_started = 0; m_passed = 0; m_timed = 0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; arm = 1'b0; log_pop = 1'b0; checkbits = 16'h0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    model_reset();
  endtask

  task automatic wait_started(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge wb_clk_i);
      if (started) begin ok = 1; break; end
    end
  endtask

  // Acceptance judged from the run length of the 2-cycle-delayed sample stream.
  task automatic model_step(input logic [15:0] cb, input logic a, input logic p);
    int n, r;
    logic [15:0] s, sm;
    bit acc;
    hist.push_back(cb);
    n = hist.size() - 1;
    s = (n >= 2) ? hist[n-2] : 16'h0;
    r = 0;
    for (int m = n; m >= 0 && r <= S; m--) begin
      sm = (m >= 2) ? hist[m-2] : 16'h0;
      if (sm != s) break;
      r++;
    end
    acc = (r == S) && (s != m_last) && (m_state != ST_IDLE);
    if (a) begin
      m_state = ST_WAIT; m_started = 0; m_passed = 0; m_timed = 0; m_count = 0;
      m_fifo.delete();
    end else begin
      if (p && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (acc) begin
        m_last = s;
        if (m_count < 255) m_count++;
        if (m_fifo.size() < 4) m_fifo.push_back(s);
      end
      case (m_state)
        ST_WAIT: if (acc && s == START) begin m_state = ST_RUN; m_started = 1; m_entry = n; end
        ST_RUN: begin
          if (acc && s == PASSC) begin m_state = ST_PASS; m_passed = 1; end
          else if (n - m_entry == T) begin m_state = ST_TMO; m_timed = 1; end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    bit ok;
    logic [15:0] code;
    int hold;

    // reset state
    repeat (2) @(negedge wb_clk_i);
    chk("rst_started", started, 0);
    chk("rst_passed", passed, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_last_code", last_code, 0);
    chk("rst_code_count", code_count, 0);
    chk("rst_log_valid", log_valid, 0);
    chk("rst_log_data", log_data, 0);

    // vector table
    vecs.push_back('{1'b1, 16'h0000,   6, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000});
    vecs.push_back('{1'b0, START,     10, 1'b1, 1'b0, 1'b0, 8'd1, START});
    vecs.push_back('{1'b0, PASSC,     10, 1'b1, 1'b1, 1'b0, 8'd2, PASSC});
    vecs.push_back('{1'b0, 16'h1234,  10, 1'b1, 1'b1, 1'b0, 8'd3, 16'h1234});
    vecs.push_back('{1'b1, 16'h0000,  10, 1'b0, 1'b0, 1'b0, 8'd1, 16'h0000});
    vecs.push_back('{1'b0, START,      3, 1'b0, 1'b0, 1'b0, 8'd1, 16'h0000});
    vecs.push_back('{1'b0, 16'h0000,   8, 1'b0, 1'b0, 1'b0, 8'd1, 16'h0000});
    vecs.push_back('{1'b0, PASSC,     10, 1'b0, 1'b0, 1'b0, 8'd2, PASSC});
    vecs.push_back('{1'b0, START,     10, 1'b1, 1'b0, 1'b0, 8'd3, START});
    vecs.push_back('{1'b0, START,    100, 1'b1, 1'b0, 1'b1, 8'd3, START});
    vecs.push_back('{1'b0, PASSC,     10, 1'b1, 1'b0, 1'b1, 8'd4, PASSC});
    vecs.push_back('{1'b1, START,     10, 1'b1, 1'b0, 1'b0, 8'd1, START});

    do_reset();
    foreach (vecs[i]) begin
      checkbits = vecs[i].code;
      arm = vecs[i].do_arm;
      @(negedge wb_clk_i);
      arm = 1'b0;
      repeat (vecs[i].cycles - 1) @(negedge wb_clk_i);
      chk($sformatf("vec%0d_started", i), started, vecs[i].e_started);
      chk($sformatf("vec%0d_passed", i), passed, vecs[i].e_passed);
      chk($sformatf("vec%0d_timed_out", i), timed_out, vecs[i].e_timed_out);
      chk($sformatf("vec%0d_code_count", i), code_count, vecs[i].e_count);
      chk($sformatf("vec%0d_last_code", i), last_code, vecs[i].e_last);
    end

    // exact timeout distance from RUN entry
    do_reset();
    checkbits = START; arm = 1'b1;
    @(negedge wb_clk_i);
    arm = 1'b0;
    wait_started(ok);
    chk("tmo_start_seen", ok, 1);
    repeat (99) @(negedge wb_clk_i);
    chk("tmo_before_tc", timed_out, 0);
    @(negedge wb_clk_i);
    chk("tmo_at_tc", timed_out, 1);
    chk("tmo_passed", passed, 0);

    // PASS acceptance on the terminal-count cycle
    do_reset();
    checkbits = START; arm = 1'b1;
    @(negedge wb_clk_i);
    arm = 1'b0;
    wait_started(ok);
    chk("race_start_seen", ok, 1);
    repeat (94) @(negedge wb_clk_i);
    checkbits = PASSC;
    repeat (5) @(negedge wb_clk_i);
    chk("race_pre_passed", passed, 0);
    chk("race_pre_timed_out", timed_out, 0);
    @(negedge wb_clk_i);
    chk("race_passed", passed, 1);
    chk("race_timed_out", timed_out, 0);
    repeat (3) @(negedge wb_clk_i);
    chk("race_hold_timed_out", timed_out, 0);

    // asynchronous reset mid-RUN, then a normal pass
    do_reset();
    checkbits = START; arm = 1'b1;
    @(negedge wb_clk_i);
    arm = 1'b0;
    wait_started(ok);
    chk("mrst_start_seen", ok, 1);
    repeat (10) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("mrst_started", started, 0);
    chk("mrst_passed", passed, 0);
    chk("mrst_timed_out", timed_out, 0);
    chk("mrst_last_code", last_code, 0);
    chk("mrst_code_count", code_count, 0);
    chk("mrst_log_valid", log_valid, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    arm = 1'b1;
    @(negedge wb_clk_i);
    arm = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    chk("mrst2_started", started, 1);
    checkbits = PASSC;
    repeat (10) @(negedge wb_clk_i);
    chk("mrst2_passed", passed, 1);
    chk("mrst2_timed_out", timed_out, 0);
    chk("mrst2_code_count", code_count, 2);
    chk("mrst2_last_code", last_code, PASSC);

    // history FIFO
    do_reset();
    arm = 1'b1;
    @(negedge wb_clk_i);
    arm = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      checkbits = 16'(v);
      repeat (8) @(negedge wb_clk_i);
    end
    chk("log_code_count", code_count, 6);
`ifdef CHECKBITS_MON_LOG_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("log_valid_%0d", i), log_valid, 1);
      chk($sformatf("log_data_%0d", i), log_data, i + 1);
      log_pop = 1'b1;
      @(negedge wb_clk_i);
      log_pop = 1'b0;
    end
    chk("log_empty_valid", log_valid, 0);
    chk("log_empty_data", log_data, 0);
`else
    log_pop = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    log_pop = 1'b0;
    chk("nolog_valid", log_valid, 0);
    chk("nolog_data", log_data, 0);
`endif

    // randomized run against the reference model
    do_reset();
    hold = 0;
    code = 16'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("rnd_started", started, m_started);
      chk("rnd_passed", passed, m_passed);
      chk("rnd_timed_out", timed_out, m_timed);
      chk("rnd_last_code", last_code, m_last);
      chk("rnd_code_count", code_count, m_count[7:0]);
`ifdef CHECKBITS_MON_LOG_EN
      chk("rnd_log_valid", log_valid, m_fifo.size() != 0);
      chk("rnd_log_data", log_data, (m_fifo.size() != 0) ? m_fifo[0] : 16'h0);
`else
      chk("rnd_log_valid", log_valid, 0);
      chk("rnd_log_data", log_data, 0);
`endif
      if (hold == 0) begin
        case ($urandom_range(0, 15))
          0:        code = PASSC;
          1, 2, 3:  code = START;
          4, 5, 6:  code = 16'h0000;
          7, 8:     code = 16'h0001;
          default:  code = 16'($urandom_range(0, 3));
        endcase
        hold = $urandom_range(1, 10);
      end
      hold--;
      checkbits = code;
      arm = (cyc == 0) || ($urandom_range(0, 149) == 0);
      log_pop = ($urandom_range(0, 3) == 0);
      @(posedge wb_clk_i);
      model_step(checkbits, arm, log_pop);
      @(negedge wb_clk_i);
    end
    arm = 1'b0;
    log_pop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/checkbits_seq_monitor.md
CHECKBITS_SEQ_MONITOR -- requirements
Module: checkbits_seq_monitor

Interface
REQ-001 Parameter START_CODE, default 16'hAB40, is the checkbits value that marks test start.
REQ-002 Parameter PASS_CODE, default 16'hAB51, is the checkbits value that marks test pass.
REQ-003 Parameter STABLE_CYCLES, default 4, range 1..15, is the number of consecutive identical synchronized samples required to accept a code.
REQ-004 Parameter TIMEOUT_CYCLES, default 24'd500000, is the cycle budget measured from the start event to the pass event.
REQ-005 Port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port checkbits, input, 16 bits: asynchronous test status bus, taken from mprj_io[31:16].
REQ-008 Port arm, input, 1 bit: one-cycle pulse that moves the FSM from IDLE to WAIT_START.
REQ-009 Port started, output, 1 bit: high from START_CODE acceptance until reset or re-arm.
REQ-010 Port passed, output, 1 bit: sticky pass flag.
REQ-011 Port timed_out, output, 1 bit: sticky timeout flag.
REQ-012 Port last_code, output, 16 bits: most recently accepted code.
REQ-013 Port code_count, output, 8 bits: number of accepted codes since arm; saturates at 8'hFF.
REQ-014 Port log_pop, input, 1 bit: pops one history entry when log_valid is high.
REQ-015 Port log_valid and log_data, outputs, 1 and 16 bits: head of the code history FIFO.

Function
REQ-016 Checkbits shall pass through a 2-flop synchronizer before any comparison; this adds 2 cycles of latency.
REQ-017 A stability counter shall reset on any change of the synchronized value; a code is accepted in the cycle the counter reaches STABLE_CYCLES, and only if it differs from last_code.
REQ-018 An acceptance shall update last_code and increment code_count (saturating) in the same cycle.
REQ-019 The FSM states shall be IDLE, WAIT_START, RUN, PASS and TIMEOUT; the encoding is free.
REQ-020 IDLE -> WAIT_START on arm. WAIT_START -> RUN on acceptance of START_CODE, which also sets started. RUN -> PASS on acceptance of PASS_CODE, which also sets passed. RUN -> TIMEOUT when the cycle counter equals TIMEOUT_CYCLES, which also sets timed_out.
REQ-021 The timeout counter shall clear on entry to RUN and increment once per cycle while in RUN.
REQ-022 If PASS_CODE acceptance and the timeout terminal count occur in the same cycle, PASS shall win.
REQ-023 PASS_CODE accepted while in WAIT_START shall be ignored for state purposes and shall still be logged and counted.
REQ-024 An arm pulse in any state other than IDLE shall return the FSM to WAIT_START and clear started, passed, timed_out, code_count, the timeout counter and the FIFO; last_code is kept.
REQ-025 PASS and TIMEOUT shall hold until reset or arm.
REQ-026 Codes shall be accepted and counted only outside IDLE.

Reset
REQ-027 On wb_rst_i: the FSM enters IDLE; started, passed and timed_out go to 0; last_code = 16'h0000; code_count = 0; the stability and timeout counters = 0; the synchronizer flops = 0; the FIFO is empty, log_valid = 0 and log_data = 0.
REQ-028 Reset asserted mid-RUN shall take effect immediately and asynchronously; the flags shall not survive it.

Configuration
REQ-029 Macro CHECKBITS_MON_LOG_EN defined: a 4-entry FIFO records every accepted code.
- log_data shows the oldest entry while log_valid is high.
- log_pop with log_valid high removes that entry.
- Writes to a full FIFO are dropped and the oldest entries are retained.
- A push and a pop in the same cycle on a full FIFO both take effect.
REQ-030 Macro CHECKBITS_MON_LOG_EN undefined: no FIFO storage is built; log_valid = 0, log_data = 0, and log_pop is ignored.

Verification
REQ-031 Arm, drive AB40 for 10 cycles, then AB51 for 10 cycles -> started = 1, passed = 1, code_count = 2, last_code = AB51, timed_out = 0.
REQ-032 With STABLE_CYCLES = 4, drive AB40 for 3 cycles, then 0000 -> AB40 is not accepted and started stays 0.
REQ-033 With TIMEOUT_CYCLES = 100, arm, drive AB40, and never drive AB51 -> timed_out = 1 exactly 100 cycles after RUN entry, and passed = 0.
REQ-034 Time AB51 acceptance to land on the same cycle as the timeout terminal count -> passed = 1, timed_out = 0.
REQ-035 Assert wb_rst_i mid-RUN -> all outputs read zero within the same cycle; a following arm plus AB40/AB51 passes normally.
REQ-036 With CHECKBITS_MON_LOG_EN defined, accept codes 0001..0006 without popping -> pop 4 times to read 0001, 0002, 0003, 0004, after which log_valid = 0; code_count = 6.
